ghr_checkpoint_ctrl: RTL and testbench

- Controller for the speculative global history register in the 2-wide superscalar out-of-order front end.
- Shifts predicted outcomes of up to two branches per cycle into the speculative GHR.
- Allocates one checkpoint slot per in-flight branch in a circular buffer.
- On a branch mispredict, restores the GHR from the branch's checkpoint with the corrected outcome and frees younger checkpoints. Commit frees the oldest slots in order.

---
 rtl/ghr_checkpoint_ctrl.sv | 74 +++++++
 tb/tb_ghr_checkpoint_ctrl.sv | 137 +++++++++++++
 2 files changed

// File: rtl/ghr_checkpoint_ctrl.sv
// ghr_checkpoint_ctrl: speculative global history with a per-branch checkpoint ring for mispredict recovery
module ghr_checkpoint_ctrl #(
  parameter int GHR_W = 5,
  parameter int DEPTH = 8,
  parameter int TAG_W = 3
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             pred_valid1,
  input  logic             pred_valid2,
  input  logic             pred_taken1,
  input  logic             pred_taken2,
  output logic             alloc_ready,
  output logic [TAG_W-1:0] tag1,
  output logic [TAG_W-1:0] tag2,
  output logic [GHR_W-1:0] ghr_spec,
  input  logic [1:0]       commit_count,
  input  logic             mispredict,
  input  logic [TAG_W-1:0] mp_tag,
  input  logic             mp_taken,
  output logic [TAG_W:0]   count,
  output logic             full
);
  localparam logic [TAG_W:0] DEPTH_C = (TAG_W+1)'(DEPTH);
  logic [GHR_W-1:0] ghr_q, ghr_d;
  logic [GHR_W-1:0] ckpt_q [DEPTH];
  logic [TAG_W-1:0] head_q, head_d, tail_q, tail_d, tail_p1, mp_dist;
  logic [TAG_W:0]   count_q, count_d, commit_req, commit_n, alloc_n;
  logic             both, fire;
  assign tail_p1     = tail_q + TAG_W'(1);
  assign both        = pred_valid1 & pred_valid2;
  assign alloc_ready = (DEPTH_C - count_q >= (TAG_W+1)'(2)) && !mispredict;
  assign fire        = alloc_ready && (pred_valid1 || pred_valid2);
  assign tag1        = tail_q;
  assign tag2        = pred_valid1 ? tail_p1 : tail_q;
  assign ghr_spec    = ghr_q;
  assign count       = count_q;
  assign full        = count_q == DEPTH_C;
  assign mp_dist     = mp_tag - head_q;
  always_comb begin
    alloc_n    = fire ? (TAG_W+1)'(pred_valid1) + (TAG_W+1)'(pred_valid2) : '0;
    commit_req = (TAG_W+1)'(commit_count);
    commit_n   = commit_req > count_q ? count_q : commit_req;
    head_d     = head_q + commit_n[TAG_W-1:0];
    // the mispredicted branch keeps its slot, everything younger is dropped
    ghr_d      = mispredict ? {ckpt_q[mp_tag][GHR_W-2:0], mp_taken} :
                 !fire      ? ghr_q :
                 both       ? {ghr_q[GHR_W-3:0], pred_taken1, pred_taken2} :
                              {ghr_q[GHR_W-2:0], pred_valid1 ? pred_taken1 : pred_taken2};
    tail_d     = mispredict ? mp_tag + TAG_W'(1) : tail_q + alloc_n[TAG_W-1:0];
    count_d    = mispredict ? (TAG_W+1)'(mp_dist) + (TAG_W+1)'(1) - commit_n
                            : count_q + alloc_n - commit_n;
  end
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      ghr_q   <= '0;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      ghr_q   <= ghr_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end
  // each checkpoint holds the history seen before its own branch shifted in
  always_ff @(posedge clock) begin
    if (fire) begin
      ckpt_q[tail_q] <= ghr_q;
      if (both) ckpt_q[tail_p1] <= {ghr_q[GHR_W-2:0], pred_taken1};
    end
  end
endmodule

// File: tb/tb_ghr_checkpoint_ctrl.sv
// tb_ghr_checkpoint_ctrl: queue-based reference model feeding a scoreboard checked by a negedge monitor
module tb_ghr_checkpoint_ctrl;
  logic       clock = 0, reset = 1;
  logic       pred_valid1 = 0, pred_valid2 = 0, pred_taken1 = 0, pred_taken2 = 0;
  logic       alloc_ready, full, mispredict = 0, mp_taken = 0;
  logic [2:0] tag1, tag2, mp_tag = 0;
  logic [4:0] ghr_spec;
  logic [1:0] commit_count = 0;
  logic [3:0] count;
  int checks = 0, errors = 0;
  typedef struct {
    bit rdy; bit c1; bit c2;
    int t1; int t2; int g; int cnt; bit f;
  } exp_t;
  exp_t exp_q[$];
  int m_head = 0, m_ghr = 0;
  int ck[$];
  ghr_checkpoint_ctrl #(.GHR_W(5), .DEPTH(8), .TAG_W(3)) dut (
    .clock(clock), .reset(reset),
    .pred_valid1(pred_valid1), .pred_valid2(pred_valid2),
    .pred_taken1(pred_taken1), .pred_taken2(pred_taken2),
    .alloc_ready(alloc_ready), .tag1(tag1), .tag2(tag2), .ghr_spec(ghr_spec),
    .commit_count(commit_count), .mispredict(mispredict), .mp_tag(mp_tag),
    .mp_taken(mp_taken), .count(count), .full(full)
  );
  always #5 clock = ~clock;
  task automatic chk(string n, logic [31:0] act, logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", n, act, req, $time);
    end
  endtask
  task automatic step(int v1, int v2, int k1, int k2, int cc, int mp, int mt, int mk, int rst);
    exp_t e;
    int size, tail, ce, idx;
    @(posedge clock);
    #1;
    reset = rst[0]; pred_valid1 = v1[0]; pred_valid2 = v2[0];
    pred_taken1 = k1[0]; pred_taken2 = k2[0]; commit_count = cc[1:0];
    mispredict = mp[0]; mp_tag = mt[2:0]; mp_taken = mk[0];
    if (rst != 0) begin
      m_head = 0; m_ghr = 0; ck.delete();
    end
    size = ck.size();
    tail = (m_head + size) % 8;
    e.rdy = (8 - size >= 2) && mp == 0;
    e.c1 = v1 != 0 && rst == 0;
    e.c2 = v2 != 0 && rst == 0;
    e.t1 = tail;
    e.t2 = v1 != 0 ? (tail + 1) % 8 : tail;
    e.g = m_ghr;
    e.cnt = size;
    e.f = size == 8;
    exp_q.push_back(e);
    if (rst == 0) begin
      ce = cc < size ? cc : size;
      if (mp != 0) begin
        idx = (mt - m_head + 8) % 8;
        m_ghr = ((ck[idx] << 1) | mk) & 31;
        while (ck.size() > idx + 1) void'(ck.pop_back());
      end else if (e.rdy && (v1 != 0 || v2 != 0)) begin
        ck.push_back(m_ghr);
        if (v1 != 0 && v2 != 0) begin
          ck.push_back(((m_ghr << 1) | k1) & 31);
          m_ghr = ((m_ghr << 2) | (k1 << 1) | k2) & 31;
        end else
          m_ghr = ((m_ghr << 1) | (v1 != 0 ? k1 : k2)) & 31;
      end
      repeat (ce) begin
        void'(ck.pop_front());
        m_head = (m_head + 1) % 8;
      end
    end
  endtask
  initial begin
    exp_t e;
    forever begin
      @(negedge clock);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("ghr_spec", 32'(ghr_spec), e.g);
        chk("count", 32'(count), e.cnt);
        chk("full", 32'(full), 32'(e.f));
        chk("alloc_ready", 32'(alloc_ready), 32'(e.rdy));
        if (e.c1) chk("tag1", 32'(tag1), e.t1);
        if (e.c2) chk("tag2", 32'(tag2), e.t2);
      end
    end
  end
  initial begin
    #500000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end
  initial begin
    int v1, v2, cc, mp, mt, idx, sz, hi;
    step(0, 0, 0, 0, 0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0);
    step(1, 1, 1, 0, 0, 0, 0, 0, 0);
    step(1, 1, 1, 1, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 1, 1, 1, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 5; i++) step(1, 0, i % 2, 0, 0, 0, 0, 0, 0);
    step(0, 1, 0, 1, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 2, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 20; i++) step(i % 2, 1 - i % 2, i % 2, i % 2, 1, 0, 0, 0, 0);
    step(0, 0, 0, 0, 2, 0, 0, 0, 0);
    step(1, 1, 0, 1, 1, 0, 0, 0, 0);
    step(1, 0, 1, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0, 1);
    step(1, 0, 1, 0, 0, 0, 0, 0, 0);
    step(0, 1, 0, 1, 0, 0, 0, 0, 0);
    for (int i = 0; i < 400; i++) begin
      v1 = int'($urandom_range(0, 1));
      v2 = int'($urandom_range(0, 1));
      sz = ck.size();
      mp = 0; mt = 0;
      cc = int'($urandom_range(0, 2));
      if (sz > 0 && $urandom_range(0, 7) == 0) begin
        mp = 1;
        hi = sz - 1 < 2 ? sz - 1 : 2;
        cc = int'($urandom_range(0, hi));
        idx = int'($urandom_range(cc, sz - 1));
        mt = (m_head + idx) % 8;
      end
      step(v1, v2, int'($urandom_range(0, 1)), int'($urandom_range(0, 1)), cc, mp, mt,
           int'($urandom_range(0, 1)), $urandom_range(0, 99) == 0 ? 1 : 0);
    end
    step(0, 0, 0, 0, 0, 0, 0, 0, 0);
    repeat (3) @(posedge clock);
    chk("scoreboard_drained", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
